// File: rtl/set_ctrl.sv
// set_ctrl: key-driven time/alarm setting controller.
// RUN -> load running time -> adjust -> commit time -> load alarm -> adjust
// -> commit alarm -> RUN. Idle timeout in either adjust state aborts to RUN
// without a commit strobe.
//
// Handshake: there is no valid/ready pair here. PE, WR_TIME and WR_ALARM are
// single-cycle strobes that the adjust counter, running clock and alarm
// register accept unconditionally on the rising CP that ends the strobe cycle.
module set_ctrl #(
  parameter int TIMEOUT = 30,
  parameter int BCD_W   = 8
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             TICK_1HZ,
  input  logic             KEY_MODE,
  input  logic             KEY_SEL,
  input  logic             KEY_UP,
  input  logic             KEY_DOWN,
  input  logic [BCD_W-1:0] T_H,
  input  logic [BCD_W-1:0] T_M,
  input  logic [BCD_W-1:0] T_S,
  input  logic [BCD_W-1:0] A_H,
  input  logic [BCD_W-1:0] A_M,
  input  logic [BCD_W-1:0] Q_H,
  input  logic [BCD_W-1:0] Q_M,
  input  logic [BCD_W-1:0] Q_S,
  output logic             H_UP,
  output logic             H_DOWN,
  output logic             M_UP,
  output logic             M_DOWN,
  output logic             S_UP,
  output logic             S_DOWN,
  output logic             PE,
  output logic [BCD_W-1:0] D_H,
  output logic [BCD_W-1:0] D_M,
  output logic [BCD_W-1:0] D_S,
  output logic             WR_TIME,
  output logic             WR_ALARM,
  output logic [BCD_W-1:0] W_H,
  output logic [BCD_W-1:0] W_M,
  output logic [BCD_W-1:0] W_S,
  output logic [1:0]       MODE,
  output logic [1:0]       FIELD,
  output logic             BLINK,
  output logic [2:0]       dbg_state
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_RUN       = 3'd0,
    S_LOAD_T    = 3'd1,
    S_SET_TIME  = 3'd2,
    S_COMMIT_T  = 3'd3,
    S_LOAD_A    = 3'd4,
    S_SET_ALARM = 3'd5,
    S_COMMIT_A  = 3'd6
  } state_t;

  state_t            state, state_nx;
  logic [1:0]        field, field_nx;
  logic              blink, blink_nx;
  logic [IDLE_W-1:0] idle_cnt, idle_nx;
  logic              mode_q, sel_q;
  logic              mode_edge, sel_edge, in_set, any_key, timeout;

  assign mode_edge = KEY_MODE & ~mode_q;
  assign sel_edge  = KEY_SEL & ~sel_q;
  assign in_set    = (state == S_SET_TIME) || (state == S_SET_ALARM);
  assign any_key   = KEY_MODE | KEY_SEL | KEY_UP | KEY_DOWN;
  // The tick that would carry the idle count up to TIMEOUT aborts instead.
  assign timeout   = in_set & ~any_key & TICK_1HZ & (idle_cnt == IDLE_LAST);

  // State, field, blink, idle counter and key-edge registers.
  always_ff @(posedge CP) begin
    if (CR) begin
      state    <= S_RUN;
      field    <= 2'd0;
      blink    <= 1'b0;
      idle_cnt <= '0;
      mode_q   <= 1'b0;
      sel_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      field    <= field_nx;
      blink    <= blink_nx;
      idle_cnt <= idle_nx;
      mode_q   <= KEY_MODE;
      sel_q    <= KEY_SEL;
    end
  end

  // Next-state logic; field and blink are held at 0 outside the adjust states.
  always_comb begin
    state_nx = state;
    field_nx = 2'd0;
    blink_nx = 1'b0;
    idle_nx  = '0;
    case (state)
      S_RUN:      if (mode_edge) state_nx = S_LOAD_T;
      S_LOAD_T: begin
        state_nx = S_SET_TIME;
        blink_nx = 1'b1;
      end
      S_COMMIT_T: state_nx = S_LOAD_A;
      S_LOAD_A: begin
        state_nx = S_SET_ALARM;
        blink_nx = 1'b1;
      end
      S_COMMIT_A: state_nx = S_RUN;
      S_SET_TIME, S_SET_ALARM: begin
        if (mode_edge) begin
          state_nx = (state == S_SET_TIME) ? S_COMMIT_T : S_COMMIT_A;
        end else if (timeout) begin
          state_nx = S_RUN;
        end else begin
          field_nx = field;
          blink_nx = blink;
          if (sel_edge) begin
            blink_nx = 1'b1;
            if (state == S_SET_TIME) field_nx = (field == 2'd2) ? 2'd0 : field + 2'd1;
            else                     field_nx = (field == 2'd0) ? 2'd1 : 2'd0;
          end else if (TICK_1HZ) begin
            blink_nx = ~blink;
          end
          if (any_key)       idle_nx = '0;
          else if (TICK_1HZ) idle_nx = idle_cnt + IDLE_W'(1);
          else               idle_nx = idle_cnt;
        end
      end
      default: state_nx = S_RUN;
    endcase
  end

  // Output decode: mode, preload, commit and direction routing.
  always_comb begin
    MODE     = 2'b00;
    PE       = 1'b0;
    D_H      = '0;
    D_M      = '0;
    D_S      = '0;
    WR_TIME  = 1'b0;
    WR_ALARM = 1'b0;
    W_H      = '0;
    W_M      = '0;
    W_S      = '0;
    H_UP     = 1'b0;
    H_DOWN   = 1'b0;
    M_UP     = 1'b0;
    M_DOWN   = 1'b0;
    S_UP     = 1'b0;
    S_DOWN   = 1'b0;
    case (state)
      S_LOAD_T: begin
        MODE = 2'b01;
        PE   = 1'b1;
        D_H  = T_H;
        D_M  = T_M;
        D_S  = T_S;
      end
      S_SET_TIME: MODE = 2'b01;
      S_COMMIT_T: begin
        MODE = 2'b01;
        // A reset in the commit cycle cancels the strobe.
        if (!CR) begin
          WR_TIME = 1'b1;
          W_H     = Q_H;
          W_M     = Q_M;
          W_S     = Q_S;
        end
      end
      S_LOAD_A: begin
        MODE = 2'b10;
        PE   = 1'b1;
        D_H  = A_H;
        D_M  = A_M;
      end
      S_SET_ALARM: MODE = 2'b10;
      S_COMMIT_A: begin
        MODE = 2'b10;
        if (!CR) begin
          WR_ALARM = 1'b1;
          W_H      = Q_H;
          W_M      = Q_M;
        end
      end
      default: MODE = 2'b00;
    endcase
    if (in_set) begin
      case (field)
        2'd0: begin H_UP = KEY_UP; H_DOWN = KEY_DOWN; end
        2'd1: begin M_UP = KEY_UP; M_DOWN = KEY_DOWN; end
        2'd2: begin S_UP = KEY_UP; S_DOWN = KEY_DOWN; end
        default: ;
      endcase
    end
  end

  assign FIELD     = field;
  assign BLINK     = blink;
  assign dbg_state = state;

endmodule

// File: doc/set_ctrl.md
SET_CTRL -- requirements
Module: set_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 30: TICK_1HZ strobes without key activity before a set mode is abandoned.
REQ-002 SHALL have parameter BCD_W, default 8: width of each 2-digit 8421 BCD field.
REQ-003 SHALL have ports (the system clock CP is the only clock; all logic is on rising CP):
 CP  in  1  system clock, rising edge
 CR  in  1  reset, synchronous, active-high
 TICK_1HZ  in  1  one-CP-cycle strobe at 1 Hz
 KEY_MODE  in  1  debounced level, mode key
 KEY_SEL  in  1  debounced level, field-select key
 KEY_UP  in  1  debounced level, increment key
 KEY_DOWN  in  1  debounced level, decrement key
 T_H, T_M, T_S  in  8  running-clock BCD time
 A_H, A_M  in  8  stored alarm BCD
 Q_H, Q_M, Q_S  in  8  adjust-counter BCD outputs
 H_UP, H_DOWN, M_UP, M_DOWN, S_UP, S_DOWN  out  1 each  adjust-counter direction levels
 PE  out  1  adjust-counter preload strobe
 D_H, D_M, D_S  out  8 each  adjust-counter preload data
 WR_TIME  out  1  one-cycle commit strobe to running clock
 WR_ALARM  out  1  one-cycle commit strobe to alarm register
 W_H, W_M, W_S  out  8 each  commit data
 MODE  out  2  00 RUN, 01 SET_TIME, 10 SET_ALARM
 FIELD  out  2  00 H, 01 M, 10 S
 BLINK  out  1  display blink of the selected field

Function
REQ-004 SHALL register KEY_MODE and KEY_SEL and act only on their rising edges (0 in cycle n-1, 1 in cycle n).
REQ-005 SHALL implement FSM states RUN, LOAD_T, SET_TIME, COMMIT_T, LOAD_A, SET_ALARM, COMMIT_A.
REQ-006 RUN: a KEY_MODE edge -> LOAD_T; all other keys ignored.
REQ-007 LOAD_T (1 cycle): PE=1, D_H/D_M/D_S=T_H/T_M/T_S, FIELD=H; then SET_TIME.
REQ-008 SET_TIME: a KEY_MODE edge -> COMMIT_T; a KEY_SEL edge cycles FIELD H->M->S->H.
REQ-009 COMMIT_T (1 cycle): WR_TIME=1, W_*=Q_*; then LOAD_A.
REQ-010 LOAD_A (1 cycle): PE=1, D_H/D_M=A_H/A_M, D_S=8'h00, FIELD=H; then SET_ALARM.
REQ-011 SET_ALARM: a KEY_MODE edge -> COMMIT_A; a KEY_SEL edge cycles FIELD H->M->H (S is never selected).
REQ-012 COMMIT_A (1 cycle): WR_ALARM=1, W_H/W_M=Q_H/Q_M, W_S=8'h00; then RUN.
REQ-013 In SET_TIME/SET_ALARM only: the UP/DOWN pair of the selected field SHALL equal KEY_UP/KEY_DOWN combinationally; the other five direction outputs SHALL be 0.
REQ-014 Direction outputs SHALL be 0 in all other states, including the LOAD and COMMIT cycles.
REQ-015 KEY_UP and KEY_DOWN both high SHALL be forwarded as both high; the adjust counter treats that as no change.
REQ-016 Outside LOAD states: PE=0, D_*=8'h00. Outside COMMIT states: WR_*=0, W_*=8'h00.
REQ-017 The idle counter SHALL be cleared when any key is high in a set state, or a KEY_MODE/KEY_SEL edge occurs. Otherwise it SHALL increment on TICK_1HZ. Its width SHALL be $clog2(TIMEOUT+1).
REQ-018 When the idle counter reaches TIMEOUT, SHALL go to RUN with no WR strobe (abort), and clear the counter.
REQ-019 Simultaneous KEY_MODE and KEY_SEL edges: the mode edge wins and FIELD is unchanged.
REQ-020 If a timeout and a KEY_MODE edge occur in the same cycle, the KEY_MODE edge wins.
REQ-021 BLINK SHALL toggle on each TICK_1HZ in SET_TIME/SET_ALARM, be forced 1 on entry to either state and on each KEY_SEL edge, and be 0 elsewhere.
REQ-022 MODE SHALL be 01 in LOAD_T, SET_TIME, COMMIT_T; 10 in LOAD_A, SET_ALARM, COMMIT_A; 00 in RUN.

Reset
REQ-023 CR=1 at a rising CP SHALL force RUN, FIELD=00, BLINK=0, idle counter=0, edge registers=0, and all outputs to 0, overriding any other input.
REQ-024 CR asserted in any set or COMMIT state SHALL produce no WR_TIME/WR_ALARM strobe in that or later cycles.

Verification
REQ-025 Mode entry: KEY_MODE pulse with T=12:34:56 -> one cycle PE=1, D=12/34/56; then MODE=01, FIELD=00.
REQ-026 Adjust routing: SET_TIME, two KEY_SEL pulses, hold KEY_UP -> FIELD=10, S_UP=1 and all other direction outputs 0; both keys held -> S_UP=S_DOWN=1.
REQ-027 Full cycle: from SET_TIME with Q=08:15:30, KEY_MODE pulse -> WR_TIME=1 for one cycle, W=08/15/30. Then, with A=06:45, PE=1, D=06/45/00. Next KEY_MODE -> WR_ALARM=1, W_S=00; then MODE=00.
REQ-028 Timeout: in SET_ALARM, no keys for 30 TICK_1HZ -> MODE=00 after the 30th tick with WR_ALARM never asserted. 29 ticks then KEY_DOWN -> stays in SET_ALARM.
REQ-029 Field wrap in SET_ALARM: KEY_SEL pulses -> FIELD 00->01->00, never 10.
REQ-030 Reset: CR=1 during SET_TIME with KEY_UP held -> next cycle MODE=00, H_UP..S_DOWN=0, no WR_TIME; a later KEY_MODE restarts at LOAD_T.
